// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and constants for the data-memory bus initiator.
//   SIZE_*          access-size encodings on the Size input
//   busState_t      FSM state encoding of mem_bus_master
//   DEFAULT_TIMEOUT default DataReady wait budget in cycles
package mem_bus_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int DEFAULT_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } busState_t;

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for the memory bus.
//   Size, AddrLo, WData, MemRData, SignExt in
//   BE, MemWData   lane-steered store enables/data
//   LoadData       extracted, extended load result
//   Misaligned     half with AddrLo[0]=1, or word with AddrLo!=0
// Low address bits that a size cannot use are simply ignored, so a
// misaligned access is naturally forced onto its aligned lanes.
module mem_lane_align
  import mem_bus_pkg::*;
(
  input  logic [1:0]  Size,
  input  logic [1:0]  AddrLo,
  input  logic [31:0] WData,
  input  logic [31:0] MemRData,
  input  logic        SignExt,
  output logic [3:0]  BE,
  output logic [31:0] MemWData,
  output logic [31:0] LoadData,
  output logic        Misaligned
);

  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  always_comb begin
    BE         = 4'b0000;
    MemWData   = '0;
    LoadData   = '0;
    Misaligned = 1'b0;
    byteVal    = 8'(MemRData >> {AddrLo, 3'b000});
    halfVal    = 16'(MemRData >> {AddrLo[1], 4'b0000});
    case (Size)
      SIZE_BYTE: begin
        BE       = 4'b0001 << AddrLo;
        MemWData = {4{WData[7:0]}};
        LoadData = SignExt ? {{24{byteVal[7]}}, byteVal} : {24'b0, byteVal};
      end
      SIZE_HALF: begin
        BE         = AddrLo[1] ? 4'b1100 : 4'b0011;
        MemWData   = {2{WData[15:0]}};
        LoadData   = SignExt ? {{16{halfVal[15]}}, halfVal} : {16'b0, halfVal};
        Misaligned = AddrLo[0];
      end
      default: begin
        // SIZE_WORD and the reserved 2'b11 both behave as a word
        BE         = 4'b1111;
        MemWData   = WData;
        LoadData   = MemRData;
        Misaligned = |AddrLo;
      end
    endcase
  end

endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: CPU-side initiator for the word-addressed data memory bus.
// Accepts one load/store at a time, drives CS/RW/BE/MemAddr/MemWData,
// waits on DataReady with a timeout, returns aligned/extended load data
// with a one-cycle Done pulse.
//   Clk, Reset_n                       clock, async active-low reset
//   Req, Wr, Size, SignExt, Addr, WData request side (sampled when Ready)
//   Ready, Done, RData, BusErr, AddrErr response side
//   CS, RW, BE, MemAddr, MemWData      registered memory bus outputs
//   MemRData, DataReady                memory return
// Build option: MEM_MISALIGN_TRAP_EN - misaligned requests complete at once
// with AddrErr instead of being forced to alignment.
//
// state | meaning
// IDLE  | Ready=1, waiting for Req
// ISSUE | one bus cycle with CS=1; stores are written here
// WAIT  | load in flight, CS held, counting DataReady-low cycles
// DONE  | Done=1 for one cycle, bus released
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 8
)(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Req,
  input  logic        Wr,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic        Ready,
  output logic        Done,
  output logic [31:0] RData,
  output logic        BusErr,
  output logic        AddrErr,
  output logic        CS,
  output logic        RW,
  output logic [3:0]  BE,
  output logic [29:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        DataReady
);

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  busState_t        state, nextState;
  logic [CNT_W-1:0] waitCnt;
  logic             wrQ, signExtQ;
  logic [1:0]       sizeQ, addrLoQ;
  logic             accept, trap, timeoutHit;

  logic [1:0]  laneSize, laneAddrLo;
  logic        laneSignExt, laneMisaligned;
  logic [3:0]  laneBE;
  logic [31:0] laneWData, laneLoad;

  // Live request fields while idle; latched fields once a load is in flight.
  assign laneSize    = (state == IDLE) ? Size       : sizeQ;
  assign laneAddrLo  = (state == IDLE) ? Addr[1:0]  : addrLoQ;
  assign laneSignExt = (state == IDLE) ? SignExt    : signExtQ;

  mem_lane_align uLane (
    .Size       (laneSize),
    .AddrLo     (laneAddrLo),
    .WData      (WData),
    .MemRData   (MemRData),
    .SignExt    (laneSignExt),
    .BE         (laneBE),
    .MemWData   (laneWData),
    .LoadData   (laneLoad),
    .Misaligned (laneMisaligned)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState  = state;
    accept     = 1'b0;
    trap       = 1'b0;
    timeoutHit = 1'b0;
    case (state)
      IDLE: begin
        if (Req) begin
          accept    = 1'b1;
          trap      = TRAP_EN && laneMisaligned;
          nextState = trap ? DONE : ISSUE;
        end
      end
      ISSUE: nextState = wrQ ? DONE : WAIT;
      WAIT: begin
        if (DataReady) begin
          nextState = DONE;
        end else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
          nextState  = DONE;
          timeoutHit = 1'b1;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs are registered from nextState so the bus sees clean levels.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Ready    <= 1'b1;
      Done     <= 1'b0;
      CS       <= 1'b0;
      RW       <= 1'b0;
      BE       <= 4'b0000;
      MemAddr  <= '0;
      MemWData <= '0;
      RData    <= '0;
      BusErr   <= 1'b0;
      AddrErr  <= 1'b0;
      waitCnt  <= '0;
      wrQ      <= 1'b0;
      signExtQ <= 1'b0;
      sizeQ    <= SIZE_BYTE;
      addrLoQ  <= 2'b00;
    end else begin
      Ready <= (nextState == IDLE);
      Done  <= (nextState == DONE);
      CS    <= (nextState == ISSUE) || (nextState == WAIT);
      RW    <= (nextState == ISSUE) && Wr;

      if (nextState == ISSUE)     BE <= laneBE;
      else if (nextState != WAIT) BE <= 4'b0000;

      if (accept) begin
        wrQ      <= Wr;
        signExtQ <= SignExt;
        sizeQ    <= Size;
        addrLoQ  <= Addr[1:0];
        MemAddr  <= Addr[31:2];
        waitCnt  <= '0;
        BusErr   <= 1'b0;
        AddrErr  <= trap;
        if (!trap) MemWData <= laneWData;
      end

      if (state == WAIT) begin
        if (DataReady) begin
          RData <= laneLoad;
        end else begin
          waitCnt <= waitCnt + 1'b1;
          if (timeoutHit) begin
            RData  <= '0;
            BusErr <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
module tb_mem_bus_master;

  localparam int TO = 15;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Req = 1'b0, Wr = 1'b0, SignExt = 1'b0, DataReady = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic [31:0] Addr = '0, WData = '0, MemRData = '0;
  logic        Ready, Done, BusErr, AddrErr, CS, RW;
  logic [31:0] RData, MemWData;
  logic [3:0]  BE;
  logic [29:0] MemAddr;

  mem_bus_master #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Wr(Wr), .Size(Size),
    .SignExt(SignExt), .Addr(Addr), .WData(WData), .Ready(Ready),
    .Done(Done), .RData(RData), .BusErr(BusErr), .AddrErr(AddrErr),
    .CS(CS), .RW(RW), .BE(BE), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .DataReady(DataReady)
  );

  always #5 Clk = ~Clk;

  int nCmp = 0, nFail = 0, cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction described by its accept cycle and the
  // cycle index (counted from the accept edge) on which Done must appear.
  bit          chkEn = 1'b0;
  int          mA = 0, mDoneK = 0;
  bit          mWr = 1'b0, mTrap = 1'b0, mBusErr = 1'b0;
  logic [3:0]  mBE = '0;
  logic [29:0] mMemAddr = '0;
  logic [31:0] mMemWData = '0, mOldRData = '0, mNewRData = '0;

  function automatic logic [3:0] expBE(input logic [1:0] sz, input logic [31:0] a);
    int off;
    off = int'(a[1:0]);
    if (sz == 2'b00) return 4'(1 << off);
    if (sz == 2'b01) return 4'(3 << (2 * (off / 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] expWData(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'b00) return wd[7:0] * 32'h01010101;
    if (sz == 2'b01) return wd[15:0] * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] expLoad(input logic [1:0] sz, input bit se,
                                          input logic [31:0] a, input logic [31:0] rd);
    int bits, sh;
    logic [31:0] v;
    if (sz == 2'b00) begin bits = 8;  sh = 8 * int'(a[1:0]); end
    else if (sz == 2'b01) begin bits = 16; sh = 16 * int'(a[1]); end
    else return rd;
    v = (rd >> sh) & ((32'h1 << bits) - 32'h1);
    if (se && v[bits-1]) v = v - (32'h1 << bits);
    return v;
  endfunction

  always @(posedge Clk) begin : cmpProc
    int k;
    logic eCS;
    #1;
    if (chkEn && Reset_n) begin
      k   = cyc - mA + 1;
      eCS = !mTrap && (k >= 1) && (k < mDoneK);
      chk("Ready", Ready, (k >= 1 && k <= mDoneK) ? 32'd0 : 32'd1);
      chk("CS", CS, eCS);
      chk("Done", Done, k == mDoneK);
      chk("RW", RW, eCS && mWr);
      chk("BE", BE, eCS ? mBE : 4'h0);
      if (eCS) chk("MemAddr", MemAddr, mMemAddr);
      if (eCS && mWr) chk("MemWData", MemWData, mMemWData);
      chk("RData", RData, (k >= mDoneK) ? mNewRData : mOldRData);
      chk("BusErr", BusErr, (k >= mDoneK) && mBusErr);
      chk("AddrErr", AddrErr, (k >= mDoneK) && mTrap);
    end
  end

  // Observations of the last transaction, for hand-computed checks.
  int          tDoneAt;
  logic        tCs1, tBusErr, tAddrErr, tCsSeen, tReadyAfter;
  logic [3:0]  tBe1;
  logic [29:0] tMa1;
  logic [31:0] tMwd1, tRd;

  // Call at a negedge with the DUT idle; returns at the negedge one cycle
  // after Done, with the DUT idle again.
  task automatic runTxn(input bit wr, input logic [1:0] sz, input bit se,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int dly, input bit reqInWait);
    bit mis, trp, tmo, pulse;
    int dk;
    mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
    trp = TRAP_EN && mis;
    tmo = !wr && !trp && (dly >= TO);
    if (trp)      dk = 1;
    else if (wr)  dk = 2;
    else if (tmo) dk = 2 + TO;
    else          dk = 3 + dly;
    pulse = reqInWait && !wr && !trp && (dk >= 4);

    mOldRData = mNewRData;
    if (!wr && !trp) mNewRData = tmo ? 32'h0 : expLoad(sz, se, a, rd);
    mA = cyc + 1; mDoneK = dk; mWr = wr; mTrap = trp; mBusErr = tmo;
    mBE = expBE(sz, a); mMemAddr = a[31:2]; mMemWData = expWData(sz, wd);

    Req = 1'b1; Wr = wr; Size = sz; SignExt = se; Addr = a; WData = wd;
    MemRData = rd; DataReady = 1'b0;
    tDoneAt = -1; tCsSeen = 0; tCs1 = 0; tBe1 = 0; tMa1 = 0; tMwd1 = 0;
    tRd = 0; tBusErr = 0; tAddrErr = 0; tReadyAfter = 0;
    for (int k = 1; k <= TO + 40; k++) begin
      @(negedge Clk);
      Req       = pulse && (k == 3);
      Wr        = 1'($urandom);
      Size      = 2'($urandom);
      SignExt   = 1'($urandom);
      Addr      = $urandom;
      WData     = $urandom;
      DataReady = !wr && (k == 2 + dly);
      if (CS) tCsSeen = 1;
      if (k == 1) begin tCs1 = CS; tBe1 = BE; tMa1 = MemAddr; tMwd1 = MemWData; end
      if (tDoneAt < 0 && Done) begin
        tDoneAt = k; tRd = RData; tBusErr = BusErr; tAddrErr = AddrErr;
      end else if (tDoneAt >= 0) begin
        tReadyAfter = Ready;
        break;
      end
    end
    Req = 1'b0; DataReady = 1'b0;
    if (tDoneAt < 0) begin
      nCmp++; nFail++;
      $display("FAIL done_bound: no Done within %0d cycles", TO + 40);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : mainProc
    bit          rWr, rSe, rPulse;
    logic [1:0]  rSz;
    logic [31:0] rA, rWd, rRd;
    int          rDly, r;

    repeat (3) @(negedge Clk);
    chk("rst_Ready", Ready, 1);
    chk("rst_CS", CS, 0);
    chk("rst_Done", Done, 0);
    chk("rst_RData", RData, 0);
    chk("rst_MemAddr", MemAddr, 0);
    Reset_n = 1'b1;
    @(negedge Clk);
    chkEn = 1'b1;
    @(negedge Clk);

    runTxn(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
    chk("stw_cs1", tCs1, 1);
    chk("stw_be", tBe1, 4'hF);
    chk("stw_addr", tMa1, 30'h4);
    chk("stw_wdata", tMwd1, 32'hDEADBEEF);
    chk("stw_done_cycle", tDoneAt, 2);

    runTxn(0, 2'b00, 1, 32'h3, 32'h0, 32'h80123456, 0, 0);
    chk("ldb_se_done_cycle", tDoneAt, 3);
    chk("ldb_se_rdata", tRd, 32'hFFFFFF80);
    runTxn(0, 2'b00, 0, 32'h3, 32'h0, 32'h80123456, 0, 0);
    chk("ldb_ze_rdata", tRd, 32'h00000080);

    runTxn(1, 2'b01, 0, 32'h2, 32'h1234ABCD, 32'h0, 0, 0);
    chk("sth_be", tBe1, 4'hC);
    chk("sth_wdata", tMwd1, 32'hABCDABCD);
    runTxn(0, 2'b01, 1, 32'h2, 32'h0, 32'h7FFF0000, 0, 0);
    chk("ldh_rdata", tRd, 32'h00007FFF);

    runTxn(0, 2'b10, 0, 32'h20, 32'h0, 32'h13572468, 3, 1);
    chk("ldw_wait3_done_cycle", tDoneAt, 6);
    chk("ldw_wait3_buserr", tBusErr, 0);
    chk("ldw_wait3_rdata", tRd, 32'h13572468);

    runTxn(0, 2'b10, 0, 32'h24, 32'h0, 32'h0BADF00D, TO - 1, 0);
    chk("ldw_lastwait_done_cycle", tDoneAt, TO + 2);
    chk("ldw_lastwait_buserr", tBusErr, 0);

    runTxn(0, 2'b10, 0, 32'h28, 32'h0, 32'h55AA55AA, 1000, 0);
    chk("tmo_done_cycle", tDoneAt, TO + 2);
    chk("tmo_buserr", tBusErr, 1);
    chk("tmo_rdata", tRd, 0);
    chk("tmo_ready_after", tReadyAfter, 1);

    // Reset in the middle of WAIT: bus released at once, no Done follows.
    mOldRData = mNewRData; mA = cyc + 1; mDoneK = 1000; mWr = 0; mTrap = 0;
    mBusErr = 0; mBE = 4'hF; mMemAddr = 30'h10;
    Req = 1'b1; Wr = 1'b0; Size = 2'b10; Addr = 32'h40; MemRData = 32'h0; DataReady = 1'b0;
    @(negedge Clk); Req = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("rstmid_cs_before", CS, 1);
    chkEn = 1'b0;
    Reset_n = 1'b0;
    #1;
    chk("rstmid_cs", CS, 0);
    chk("rstmid_ready", Ready, 1);
    chk("rstmid_done", Done, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    mA = 0; mDoneK = 0; mOldRData = 0; mNewRData = 0; mBusErr = 0; mTrap = 0;
    chkEn = 1'b1;
    repeat (4) @(negedge Clk);

    runTxn(0, 2'b10, 0, 32'h6, 32'h0, 32'hCAFEF00D, 0, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("misw_done_cycle", tDoneAt, 1);
    chk("misw_addrerr", tAddrErr, 1);
    chk("misw_cs_seen", tCsSeen, 0);
`else
    chk("misw_addr", tMa1, 30'h1);
    chk("misw_be", tBe1, 4'hF);
    chk("misw_addrerr", tAddrErr, 0);
    chk("misw_rdata", tRd, 32'hCAFEF00D);
`endif

    for (int i = 0; i < 80; i++) begin
      rWr = 1'($urandom);
      rSz = 2'($urandom);
      rSe = 1'($urandom);
      rA  = $urandom;
      rWd = $urandom;
      rRd = $urandom;
      r   = int'($urandom_range(0, 9));
      if (r < 6)      rDly = int'($urandom_range(0, 4));
      else if (r < 8) rDly = int'($urandom_range(TO - 2, TO + 2));
      else            rDly = int'($urandom_range(5, TO));
      rPulse = 1'($urandom);
      runTxn(rWr, rSz, rSe, rA, rWd, rRd, rDly, rPulse);
    end

    repeat (3) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
